// File: rtl/row_window_ctrl.sv
// ---------------------------------------------------------------------------
// row_window_ctrl
//
// Builds a 5-pixel vertical window (current row plus the four rows above it)
// from a raster pixel stream, using four external single-port row RAMs that
// share one address/enable. Each accepted pixel costs two clocks:
//   RD : read all four row RAMs at the current column
//   WR : shift the column down one RAM (RAM1 <- new pixel, RAMk+1 <- RAMk)
//        and register the 5-pixel column onto m_data.
//
// Parameters
//   P_ROW_WIDTH   pixels per image row
//   P_DATA_WIDTH  pixel width
//   P_ADDR_WIDTH  row-RAM address width
//
// Ports
//   clka       clock, all logic on the rising edge
//   rsta       asynchronous, active-high reset
//   s_valid    input pixel valid
//   s_ready    input pixel accepted when s_valid && s_ready
//   s_data     input pixel, raster order
//   s_sof      marks the accepted beat as the first pixel of a frame
//   ram_en     common enable of the four row RAMs
//   ram_addr   common RAM address (current column)
//   ram_we     bit k = write enable of row RAM k+1
//   ram_din    slice k = write data of row RAM k+1
//   ram_dout   slice k = read data of row RAM k+1 (one-cycle latency)
//   m_valid    one-cycle pulse, 5-pixel column valid
//   m_data     slice 0 = current row ... slice 4 = row four lines earlier
//   m_eol      high with m_valid on the last column of a row
//
// Configuration
//   ROW_BORDER_REPLICATE_EN  when defined, columns are emitted from row 0 on;
//                            rows above the top of the frame are filled by
//                            replicating the oldest valid row. When undefined,
//                            nothing is emitted until four rows are stored.
// ---------------------------------------------------------------------------
module row_window_ctrl #(
   parameter int P_ROW_WIDTH  = 256,
   parameter int P_DATA_WIDTH = 8,
   parameter int P_ADDR_WIDTH = 11
) (
   input  logic                      clka,
   input  logic                      rsta,
   input  logic                      s_valid,
   output logic                      s_ready,
   input  logic [P_DATA_WIDTH-1:0]   s_data,
   input  logic                      s_sof,
   output logic                      ram_en,
   output logic [P_ADDR_WIDTH-1:0]   ram_addr,
   output logic [3:0]                ram_we,
   output logic [4*P_DATA_WIDTH-1:0] ram_din,
   input  logic [4*P_DATA_WIDTH-1:0] ram_dout,
   output logic                      m_valid,
   output logic [5*P_DATA_WIDTH-1:0] m_data,
   output logic                      m_eol
);

   localparam int DW = P_DATA_WIDTH;
   localparam logic [P_ADDR_WIDTH-1:0] LAST_COL = P_ADDR_WIDTH'(P_ROW_WIDTH - 1);
   localparam logic [P_ADDR_WIDTH-1:0] ONE_COL  = P_ADDR_WIDTH'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2
   } state_t;

   state_t                    state_q, state_d;
   logic [P_ADDR_WIDTH-1:0]   col_q, col_d;
   logic [2:0]                rows_q, rows_d;      // completed rows, saturates at 4
   logic [DW-1:0]             pix_q, pix_d;
   logic                      m_valid_q, m_valid_d;
   logic                      m_eol_q, m_eol_d;
   logic [5*DW-1:0]           m_data_q, m_data_d;

   logic                      accept;
   logic [5*DW-1:0]           raw_col;             // {RAM4..RAM1, new pixel}
   logic [5*DW-1:0]           win_col;             // raw_col after border handling
   logic                      win_show;            // this column may be emitted

   assign s_ready = (state_q == ST_IDLE) || (state_q == ST_WR);
   assign accept  = s_valid && s_ready;
   assign raw_col = {ram_dout, pix_q};

   // -------------------------------------------------------------------------
   // Top-border handling
   // -------------------------------------------------------------------------
`ifdef ROW_BORDER_REPLICATE_EN
   logic [2:0] src_row;

   // Rows that do not exist yet (k > rows_q) take the oldest stored row, so
   // stale RAM contents from a previous frame never reach m_data.
   always_comb begin
      win_col  = raw_col;
      win_show = 1'b1;
      src_row  = 3'd0;
      for (int k = 1; k < 5; k++) begin
         src_row = (3'(k) > rows_q) ? rows_q : 3'(k);
         win_col[k*DW +: DW] = raw_col[src_row*DW +: DW];
      end
   end
`else
   always_comb begin
      win_col  = raw_col;
      win_show = (rows_q == 3'd4);
   end
`endif

   // -------------------------------------------------------------------------
   // Next-state, datapath and RAM control
   // -------------------------------------------------------------------------
   // NOTE: every signal written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      col_d     = col_q;
      rows_d    = rows_q;
      pix_d     = pix_q;
      m_data_d  = m_data_q;
      m_valid_d = 1'b0;
      m_eol_d   = 1'b0;
      ram_en    = 1'b0;
      ram_we    = 4'b0000;
      ram_addr  = col_q;
      ram_din   = '0;

      unique case (state_q)
         ST_IDLE: begin
            if (accept) state_d = ST_RD;
         end

         ST_RD: begin
            ram_en  = 1'b1;
            state_d = ST_WR;
         end

         ST_WR: begin
            ram_en    = 1'b1;
            ram_we    = 4'b1111;
            // Shift the column down by one row RAM; RAM4's old data drops out.
            ram_din   = {ram_dout[3*DW-1:0], pix_q};
            m_data_d  = win_show ? win_col : m_data_q;
            m_valid_d = win_show;
            m_eol_d   = win_show && (col_q == LAST_COL);

            if (col_q == LAST_COL) begin
               col_d = '0;
               if (rows_q != 3'd4) rows_d = rows_q + 3'd1;
            end else begin
               col_d = col_q + ONE_COL;
            end

            state_d = accept ? ST_RD : ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase

      // A start-of-frame beat overrides the column advance above so the new
      // pixel lands in column 0 of a frame with no stored rows.
      if (accept) begin
         pix_d = s_data;
         if (s_sof) begin
            col_d  = '0;
            rows_d = 3'd0;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values computed above.
   always_ff @(posedge clka or posedge rsta) begin
      if (rsta) begin
         state_q   <= ST_IDLE;
         col_q     <= '0;
         rows_q    <= 3'd0;
         pix_q     <= '0;
         m_valid_q <= 1'b0;
         m_eol_q   <= 1'b0;
         m_data_q  <= '0;
      end else begin
         state_q   <= state_d;
         col_q     <= col_d;
         rows_q    <= rows_d;
         pix_q     <= pix_d;
         m_valid_q <= m_valid_d;
         m_eol_q   <= m_eol_d;
         m_data_q  <= m_data_d;
      end
   end

   assign m_valid = m_valid_q;
   assign m_eol   = m_eol_q;
   assign m_data  = m_data_q;

endmodule
